// File: rtl/mux2_arbiter_if.sv
// Request/grant and data bundle between two requesters and the mux2_arbiter.
// The slave modport is the arbiter's view; master is the requesters' side.
interface mux2_arbiter_if #(
    parameter int WIDTH = 8
);
    logic             req0;
    logic             req1;
    logic [WIDTH-1:0] d0;
    logic [WIDTH-1:0] d1;
    logic             gnt0;
    logic             gnt1;
    logic             sel;
    logic [WIDTH-1:0] out;
    logic             valid;

    modport slave (
        input  req0, req1, d0, d1,
        output gnt0, gnt1, sel, out, valid
    );

    modport master (
        output req0, req1, d0, d1,
        input  gnt0, gnt1, sel, out, valid
    );
endinterface

// File: rtl/mux2_arbiter.sv
// Round-robin two-requester arbiter with locked grants driving a shared 2:1 mux.
// Optional burst limiting under contention is enabled by defining ARB_BURST_LIMIT_EN.
module mux2_arbiter #(
    parameter int WIDTH     = 8,
    parameter int BURST_MAX = 4
) (
    input logic           clk,
    input logic           reset,
    mux2_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    state_t stateQ, stateD;
    logic   lastQ, lastD;
    logic   selQ, selD;
    logic   limit0, limit1;

    if (BURST_MAX < 1 || BURST_MAX > 255) begin : gBadBurstMax
        $error("mux2_arbiter: BURST_MAX must be in 1..255");
    end

`ifdef ARB_BURST_LIMIT_EN
    localparam logic [7:0] BurstLast = 8'(BURST_MAX - 1);

    logic [7:0] burstQ, burstD;

    // The holder is forced off only when its burst is used up and the other side waits.
    assign limit0 = (burstQ == BurstLast) && bus.req1;
    assign limit1 = (burstQ == BurstLast) && bus.req0;
`else
    assign limit0 = 1'b0;
    assign limit1 = 1'b0;
`endif

    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            IDLE: begin
                if (bus.req0 && !bus.req1) begin
                    stateD = G0;
                end else if (!bus.req0 && bus.req1) begin
                    stateD = G1;
                end else if (bus.req0 && bus.req1) begin
                    stateD = lastQ ? G0 : G1;
                end
            end
            G0: begin
                if (bus.req0 && !limit0) begin
                    stateD = G0;
                end else if (bus.req1) begin
                    stateD = G1;
                end else begin
                    stateD = IDLE;
                end
            end
            G1: begin
                if (bus.req1 && !limit1) begin
                    stateD = G1;
                end else if (bus.req0) begin
                    stateD = G0;
                end else begin
                    stateD = IDLE;
                end
            end
            default: stateD = IDLE;
        endcase
    end

    // last and sel only move on entry into a grant, so sel holds through IDLE.
    always_comb begin
        lastD = lastQ;
        selD  = selQ;
        if (stateD == G0 && stateQ != G0) begin
            lastD = 1'b0;
            selD  = 1'b0;
        end else if (stateD == G1 && stateQ != G1) begin
            lastD = 1'b1;
            selD  = 1'b1;
        end
    end

`ifdef ARB_BURST_LIMIT_EN
    always_comb begin
        burstD = burstQ;
        if (stateD != stateQ && stateD != IDLE) begin
            burstD = 8'd0;
        end else if (stateD == stateQ && stateQ != IDLE && burstQ != BurstLast) begin
            burstD = burstQ + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            burstQ <= 8'd0;
        end else begin
            burstQ <= burstD;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateQ <= IDLE;
            lastQ  <= 1'b1;
            selQ   <= 1'b0;
        end else begin
            stateQ <= stateD;
            lastQ  <= lastD;
            selQ   <= selD;
        end
    end

    assign bus.gnt0  = (stateQ == G0);
    assign bus.gnt1  = (stateQ == G1);
    assign bus.sel   = selQ;
    assign bus.valid = (stateQ == G0) || (stateQ == G1);
    assign bus.out   = selQ ? bus.d1 : bus.d0;

endmodule

// File: tb/tb_mux2_arbiter.sv
// Scoreboard bench for mux2_arbiter: directed scenarios plus a random run
// against a reference model; honours ARB_BURST_LIMIT_EN like the design.
module tb_mux2_arbiter;

    localparam int W  = 8;
    localparam int BM = 4;
`ifdef ARB_BURST_LIMIT_EN
    localparam bit LimitOn = 1'b1;
`else
    localparam bit LimitOn = 1'b0;
`endif

    typedef struct {
        logic         g0;
        logic         g1;
        logic         s;
        logic         v;
        logic [W-1:0] o;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;
    exp_t expQ[$];
    exp_t e;

    int   mG;
    int   mCnt;
    logic mLast;
    logic mSel;

    always #5 clk = ~clk;

    mux2_arbiter_if #(.WIDTH(W)) bus ();

    mux2_arbiter #(
        .WIDTH    (W),
        .BURST_MAX(BM)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    function automatic exp_t mkExp(input logic g0, input logic g1, input logic s);
        exp_t x;
        x.g0 = g0;
        x.g1 = g1;
        x.s  = s;
        x.v  = g0 | g1;
        x.o  = s ? bus.d1 : bus.d0;
        return x;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset    = 1'b1;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        bus.d0   = 8'hA5;
        bus.d1   = 8'h3C;
        bus.req0 = 1'b0;
        bus.req1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: begin reset = 1'b1; #2; expQ.push_back(mkExp(1'b0, 1'b0, 1'b0)); end
                1: begin reset = 1'b0; expQ.push_back(mkExp(1'b0, 1'b1, 1'b1)); tick(); end
                2: begin expQ.push_back(mkExp(1'b0, 1'b1, 1'b1)); tick(); end
                3: begin #2; reset = 1'b1; #1; expQ.push_back(mkExp(1'b0, 1'b0, 1'b0)); end
                default: begin
                    bus.req0 = 1'b1;
                    bus.req1 = 1'b1;
                    #1;
                    reset = 1'b0;
                    expQ.push_back(mkExp(1'b1, 1'b0, 1'b0));
                    tick();
                end
            endcase
            e = expQ.pop_front();
            checks++;
            if ({bus.gnt0, bus.gnt1, bus.sel, bus.valid, bus.out} !== {e.g0, e.g1, e.s, e.v, e.o}) begin
                errors++;
                $display("[TB] FAIL reset[%0d]: got g0=%b g1=%b sel=%b valid=%b out=%h, want g0=%b g1=%b sel=%b valid=%b out=%h",
                         i, bus.gnt0, bus.gnt1, bus.sel, bus.valid, bus.out, e.g0, e.g1, e.s, e.v, e.o);
            end
        end
    endtask

    task automatic test_single();
        doReset();
        bus.d0 = 8'hA5;
        bus.d1 = 8'h3C;
        for (int i = 0; i < 2; i++) begin
            bus.req0 = (i == 0);
            expQ.push_back(mkExp(i == 0, 1'b0, 1'b0));
            tick();
            e = expQ.pop_front();
            checks++;
            if ({bus.gnt0, bus.gnt1, bus.sel, bus.valid, bus.out} !== {e.g0, e.g1, e.s, e.v, e.o}) begin
                errors++;
                $display("[TB] FAIL single[%0d]: got g0=%b g1=%b sel=%b valid=%b out=%h, want g0=%b g1=%b sel=%b valid=%b out=%h",
                         i, bus.gnt0, bus.gnt1, bus.sel, bus.valid, bus.out, e.g0, e.g1, e.s, e.v, e.o);
            end
        end
    endtask

    task automatic test_handoff();
        doReset();
        bus.d0 = 8'h11;
        bus.d1 = 8'h22;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: begin bus.req0 = 1'b1; bus.req1 = 1'b1; expQ.push_back(mkExp(1'b1, 1'b0, 1'b0)); end
                1: begin bus.req0 = 1'b0; expQ.push_back(mkExp(1'b0, 1'b1, 1'b1)); end
                default: begin bus.req1 = 1'b0; expQ.push_back(mkExp(1'b0, 1'b0, 1'b1)); end
            endcase
            tick();
            e = expQ.pop_front();
            checks++;
            if ({bus.gnt0, bus.gnt1, bus.sel, bus.valid, bus.out} !== {e.g0, e.g1, e.s, e.v, e.o}) begin
                errors++;
                $display("[TB] FAIL handoff[%0d]: got g0=%b g1=%b sel=%b valid=%b out=%h, want g0=%b g1=%b sel=%b valid=%b out=%h",
                         i, bus.gnt0, bus.gnt1, bus.sel, bus.valid, bus.out, e.g0, e.g1, e.s, e.v, e.o);
            end
        end
    endtask

    task automatic test_round_robin();
        int   grp;
        logic busy;
        doReset();
        bus.d0 = 8'h5A;
        bus.d1 = 8'hC3;
        for (int i = 0; i < 12; i++) begin
            grp      = (i / 3) % 2;
            busy     = (i % 3) != 2;
            bus.req0 = busy;
            bus.req1 = busy;
            expQ.push_back(mkExp(busy && grp == 0, busy && grp == 1, grp[0]));
            tick();
            e = expQ.pop_front();
            checks++;
            if ({bus.gnt0, bus.gnt1, bus.sel, bus.valid, bus.out} !== {e.g0, e.g1, e.s, e.v, e.o}) begin
                errors++;
                $display("[TB] FAIL roundrobin[%0d]: got g0=%b g1=%b sel=%b valid=%b out=%h, want g0=%b g1=%b sel=%b valid=%b out=%h",
                         i, bus.gnt0, bus.gnt1, bus.sel, bus.valid, bus.out, e.g0, e.g1, e.s, e.v, e.o);
            end
        end
    endtask

    task automatic test_burst();
        int idx;
        doReset();
        bus.d0 = 8'h01;
        bus.d1 = 8'h02;
        for (int i = 0; i < 12; i++) begin
            idx      = LimitOn ? (i / 4) % 2 : 0;
            bus.req0 = 1'b1;
            bus.req1 = 1'b1;
            expQ.push_back(mkExp(idx == 0, idx == 1, idx[0]));
            tick();
            e = expQ.pop_front();
            checks++;
            if ({bus.gnt0, bus.gnt1, bus.sel, bus.valid, bus.out} !== {e.g0, e.g1, e.s, e.v, e.o}) begin
                errors++;
                $display("[TB] FAIL burst[%0d]: got g0=%b g1=%b sel=%b valid=%b out=%h, want g0=%b g1=%b sel=%b valid=%b out=%h",
                         i, bus.gnt0, bus.gnt1, bus.sel, bus.valid, bus.out, e.g0, e.g1, e.s, e.v, e.o);
            end
        end
    endtask

    // A long uncontended hold must leave the counter saturated, so a late rival wins at once.
    task automatic test_burst_saturate();
        int idx;
        doReset();
        bus.d0 = 8'h77;
        bus.d1 = 8'h88;
        for (int i = 0; i < 10; i++) begin
            idx      = (LimitOn && i >= 8) ? 1 : 0;
            bus.req0 = 1'b1;
            bus.req1 = (i >= 8);
            expQ.push_back(mkExp(idx == 0, idx == 1, idx[0]));
            tick();
            e = expQ.pop_front();
            checks++;
            if ({bus.gnt0, bus.gnt1, bus.sel, bus.valid, bus.out} !== {e.g0, e.g1, e.s, e.v, e.o}) begin
                errors++;
                $display("[TB] FAIL saturate[%0d]: got g0=%b g1=%b sel=%b valid=%b out=%h, want g0=%b g1=%b sel=%b valid=%b out=%h",
                         i, bus.gnt0, bus.gnt1, bus.sel, bus.valid, bus.out, e.g0, e.g1, e.s, e.v, e.o);
            end
        end
    endtask

    task automatic test_random();
        int   nxt;
        logic r0, r1;
        doReset();
        mG    = 0;
        mCnt  = 0;
        mLast = 1'b1;
        mSel  = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(3) == 0) bus.req0 = ~bus.req0;
            if ($urandom_range(3) == 0) bus.req1 = ~bus.req1;
            bus.d0 = 8'($urandom);
            bus.d1 = 8'($urandom);
            r0 = bus.req0;
            r1 = bus.req1;
            if (mG == 1 && r0) begin
                nxt = (LimitOn && mCnt == BM - 1 && r1) ? 2 : 1;
            end else if (mG == 2 && r1) begin
                nxt = (LimitOn && mCnt == BM - 1 && r0) ? 1 : 2;
            end else if (r0 && r1) begin
                nxt = mLast ? 1 : 2;
            end else if (r0) begin
                nxt = 1;
            end else if (r1) begin
                nxt = 2;
            end else begin
                nxt = 0;
            end
            if (nxt != 0 && nxt != mG) begin
                mCnt  = 0;
                mLast = (nxt == 2);
                mSel  = (nxt == 2);
            end else if (nxt != 0 && mCnt < BM - 1) begin
                mCnt++;
            end
            mG = nxt;
            expQ.push_back(mkExp(mG == 1, mG == 2, mSel));
            tick();
            e = expQ.pop_front();
            checks++;
            if ({bus.gnt0, bus.gnt1, bus.sel, bus.valid, bus.out} !== {e.g0, e.g1, e.s, e.v, e.o}) begin
                errors++;
                $display("[TB] FAIL random[%0d]: got g0=%b g1=%b sel=%b valid=%b out=%h, want g0=%b g1=%b sel=%b valid=%b out=%h",
                         i, bus.gnt0, bus.gnt1, bus.sel, bus.valid, bus.out, e.g0, e.g1, e.s, e.v, e.o);
            end
            checks++;
            if ((bus.gnt0 & bus.gnt1) !== 1'b0) begin
                errors++;
                $display("[TB] FAIL exclusive[%0d]: gnt0=%b gnt1=%b, want not both high", i, bus.gnt0, bus.gnt1);
            end
            checks++;
            if (bus.valid !== (bus.gnt0 | bus.gnt1)) begin
                errors++;
                $display("[TB] FAIL validOr[%0d]: valid=%b, want %b", i, bus.valid, bus.gnt0 | bus.gnt1);
            end
            checks++;
            if (bus.out !== (bus.sel ? bus.d1 : bus.d0)) begin
                errors++;
                $display("[TB] FAIL muxOut[%0d]: out=%h, want %h", i, bus.out, bus.sel ? bus.d1 : bus.d0);
            end
        end
    endtask

    initial begin
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.d0   = '0;
        bus.d1   = '0;
        $display("[TB] mux2_arbiter bench, burst limit %s", LimitOn ? "enabled" : "disabled");
        test_reset();
        test_single();
        test_handoff();
        test_round_robin();
        test_burst();
        test_burst_saturate();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux2_arbiter.md
Name: mux2_arbiter

Overview:
- Round-robin arbiter and controller for a shared WIDTH-bit 2:1 mux datapath between two requesters.
- Each requester raises a request and receives a locked grant.
- The block drives the mux select from its grant state and presents the selected data with a valid flag.
- It sits in front of any single-ported resource shared by two sources, such as a register write port or a bus.

Parameters:
- WIDTH, 8, data width of each requester's operand and of the muxed output.
- BURST_MAX, 4, maximum consecutive grant cycles under contention (used only with the optional feature); legal range 1..255.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- req0  in  1  request from requester 0; held high for as long as it needs the resource.
- req1  in  1  request from requester 1; held high for as long as it needs the resource.
- d0  in  WIDTH  requester 0 data.
- d1  in  WIDTH  requester 1 data.
- gnt0  out  1  grant to requester 0 (registered).
- gnt1  out  1  grant to requester 1 (registered).
- sel  out  1  mux select (registered); 0 selects d0, 1 selects d1.
- out  out  WIDTH  muxed data, combinational: sel ? d1 : d0.
- valid  out  1  gnt0 | gnt1.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-grant):
  - state=IDLE; gnt0=gnt1=0; sel=0; valid=0.
  - last=1 (last-served index), so requester 0 wins the first tie.
  - burst counter=0.
  - out follows d0 while in reset.
- States: IDLE, G0, G1. gnt0 = (state==G0); gnt1 = (state==G1). The two grants are never high together.
- Latency: request sampled at edge N produces a grant visible after edge N. Data path latency is 0 (out is combinational from d0/d1 via the registered sel).
- IDLE transitions:
  - req0 & ~req1 -> G0.
  - ~req0 & req1 -> G1.
  - req0 & req1 -> G0 if last==1, else G1.
  - Neither request -> stay in IDLE.
- G0 transitions:
  - req0 high -> stay in G0 (grant locked; req1 is ignored).
  - req0 low and req1 high -> G1 directly, with no idle bubble.
  - req0 low and req1 low -> IDLE.
- G1 transitions: symmetric with G0, with the roles of req0 and req1 swapped.
- last is updated on entry to a grant state: last=0 on entering G0, last=1 on entering G1.
- sel is updated on entry to a grant state: 0 on entering G0, 1 on entering G1. sel holds its value through IDLE so out does not glitch.
- Releasing a grant:
  - The requester drops req after its final transfer cycle.
  - gnt drops at the next edge; that extra cycle still shows valid=1 with the same sel.
- A request that drops in the same cycle it would have been granted is not granted.

Optional Feature:
- Macro: ARB_BURST_LIMIT_EN.
- When defined:
  - An 8-bit burst counter clears on every entry into G0 or G1 and increments each cycle the state is held.
  - If the counter equals BURST_MAX-1 and the opposite request is high, the next state is the other grant state, even if the current requester still holds req. last and sel update as on any entry.
  - If the opposite request is low, the grant persists and the counter saturates at BURST_MAX-1.
- When undefined:
  - No counter is built.
  - The grant is held while req stays high; the other requester can be starved.

Test Plan:
- Async reset mid-grant: in G1 with req1=1, assert reset between edges -> gnt1=0, sel=0, valid=0 immediately, without waiting for an edge. Release reset with req0=req1=1 -> G0 at the next edge.
- Single requester: req0=1, d0=8'hA5, d1=8'h3C -> after 1 edge, gnt0=1, sel=0, valid=1, out=8'hA5. Drop req0 -> at the next edge gnt0=0, valid=0, sel stays 0.
- Direct handoff: after reset, req0=req1=1, d0=8'h11, d1=8'h22 -> G0, out=8'h11. Drop req0 -> at the next edge gnt1=1, sel=1, out=8'h22, with no cycle where valid=0.
- Round-robin tie: alternate bursts of 2 cycles with both req held, separated by an idle cycle with both low -> grant order G0, G1, G0, G1. sel holds its last value during each IDLE cycle.
- Burst limit with BURST_MAX=4, req0=req1=1 held for 12 cycles:
  - With ARB_BURST_LIMIT_EN: gnt0 for 4 cycles, gnt1 for 4 cycles, gnt0 for 4 cycles.
  - Without the macro: gnt0 for all 12 cycles and gnt1 never asserts.
- Exclusivity check: random req0/req1 stimulus for 1000 cycles.
  - Assert that gnt0 and gnt1 are never high together.
  - Assert valid == gnt0|gnt1 and out == (sel ? d1 : d0) on every cycle.
